axi_master_bfm: RTL

Synthesizable AXI3 master traffic engine, the initiator counterpart to the AXI slave bus functional model. It accepts one burst command at a time from a local command port and issues it as either a write burst (AW, W, B) or a read burst (AR, R). Write data follows a deterministic pattern, and read data is checked against the same pattern. It sits in the testbench or self-test fabric and drives the slave model's ports one-to-one.

---
 rtl/axi_master_bfm.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_master_bfm.sv
// AXI3 master traffic engine: one burst at a time from a command port,
// patterned write data, read data checked against the same pattern.
module axi_master_bfm #(
    parameter int TIMEOUT = 1024
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [3:0]  cmd_id,
    input  logic [31:0] cmd_data,
    output logic        done,
    output logic [1:0]  done_resp,
    output logic        timeout,
    output logic [15:0] mismatch_count,
    output logic [3:0]  awid,
    output logic [31:0] awadr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wrdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int          WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [31:0] TO_M1 = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]      r_id;
    logic [3:0]      r_len;
    logic [31:0]     r_seed;
    logic [3:0]      r_beat;
    logic [1:0]      r_worst;
    logic            r_to;
    logic [15:0]     r_mm;
    logic [WD_W-1:0] r_wd;

    logic [3:0]  r_awid;
    logic [31:0] r_awadr;
    logic [3:0]  r_awlen;
    logic [3:0]  r_wid;
    logic [31:0] r_wrdata;
    logic        r_wlast;
    logic [3:0]  r_arid;
    logic [31:0] r_araddr;
    logic [3:0]  r_arlen;

    logic        w_accept;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_b_hs;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_hs;
    logic        w_wait;
    logic        w_expire;
    logic        w_last_beat;
    logic [31:0] w_exp_rdata;
    logic        w_r_bad;

    assign w_accept    = (r_state == S_IDLE) && cmd_valid;
    assign w_aw_hs     = (r_state == S_AW) && awready;
    assign w_w_hs      = (r_state == S_W) && wready;
    assign w_b_hs      = (r_state == S_B) && bvalid;
    assign w_ar_hs     = (r_state == S_AR) && arready;
    assign w_r_hs      = (r_state == S_R) && rvalid;
    assign w_hs        = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;
    assign w_wait      = (r_state == S_AW) || (r_state == S_W) ||
                         (r_state == S_B) || (r_state == S_AR) ||
                         (r_state == S_R);
    assign w_expire    = (TIMEOUT != 0) && w_wait && !w_hs &&
                         (r_wd == TO_M1[WD_W-1:0]);
    assign w_last_beat = (r_beat == r_len);
    assign w_exp_rdata = r_seed + {28'd0, r_beat};
    assign w_r_bad     = (rdata != w_exp_rdata) || (rid != r_id) ||
                         (rlast != w_last_beat);

    // State register
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-state handshake outputs
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = cmd_write ? S_AW : S_AR;
                end
            end
            S_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    w_next = S_W;
                end
            end
            S_W: begin
                wvalid = 1'b1;
                if (wready && w_last_beat) begin
                    w_next = S_B;
                end
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_next = S_DONE;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_next = S_R;
                end
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid && w_last_beat) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_expire) begin
            w_next = S_DONE;
        end
    end

    // Watchdog: consecutive stalled cycles within one wait state
    always_ff @(posedge aclk) begin
        if (areset || !w_wait || w_hs || (w_next != r_state)) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + WD_W'(1);
        end
    end

    // Command capture, payload registers, response and check tracking
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_id     <= '0;
            r_len    <= '0;
            r_seed   <= '0;
            r_beat   <= '0;
            r_worst  <= '0;
            r_to     <= 1'b0;
            r_mm     <= '0;
            r_awid   <= '0;
            r_awadr  <= '0;
            r_awlen  <= '0;
            r_wid    <= '0;
            r_wrdata <= '0;
            r_wlast  <= 1'b0;
            r_arid   <= '0;
            r_araddr <= '0;
            r_arlen  <= '0;
        end else begin
            if (w_accept) begin
                r_id    <= cmd_id;
                r_len   <= cmd_len;
                r_seed  <= cmd_data;
                r_beat  <= '0;
                r_worst <= '0;
                r_to    <= 1'b0;
                if (cmd_write) begin
                    r_awid   <= cmd_id;
                    r_awadr  <= cmd_addr;
                    r_awlen  <= cmd_len;
                    r_wid    <= cmd_id;
                    r_wrdata <= cmd_data;
                    r_wlast  <= (cmd_len == 4'd0);
                end else begin
                    r_arid   <= cmd_id;
                    r_araddr <= cmd_addr;
                    r_arlen  <= cmd_len;
                end
            end
            if (w_w_hs) begin
                r_beat   <= r_beat + 4'd1;
                r_wrdata <= r_wrdata + 32'd1;
                r_wlast  <= !w_last_beat && ((r_beat + 4'd1) == r_len);
            end
            if (w_b_hs) begin
                if (bresp > r_worst) begin
                    r_worst <= bresp;
                end
                if ((bid != r_id) && (r_mm != 16'hFFFF)) begin
                    r_mm <= r_mm + 16'd1;
                end
            end
            if (w_r_hs) begin
                r_beat <= r_beat + 4'd1;
                if (rresp > r_worst) begin
                    r_worst <= rresp;
                end
                if (w_r_bad && (r_mm != 16'hFFFF)) begin
                    r_mm <= r_mm + 16'd1;
                end
            end
            if (w_expire) begin
                r_worst <= 2'b11;
                r_to    <= 1'b1;
            end
        end
    end

    assign done_resp      = r_worst;
    assign timeout        = r_to && (r_state == S_DONE);
    assign mismatch_count = r_mm;

    assign awid    = r_awid;
    assign awadr   = r_awadr;
    assign awlen   = r_awlen;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'h0;
    assign awprot  = 3'h0;

    assign wid    = r_wid;
    assign wrdata = r_wrdata;
    assign wstrb  = 4'hF;
    assign wlast  = r_wlast;

    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'h0;
    assign arprot  = 3'h0;

endmodule
